// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register bank read port on request and streams
// every register (and optionally the link register) out on a valid/ready
// interface, one word per READ/SEND pair.
module reg_dump_reader #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int INCLUDE_LINK = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_value,
    input  logic [DATA_W-1:0] link_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = ADDR_W + 1;

    // Index of the final word: the link slot when it is emitted, else the top register.
    localparam logic [IDX_W-1:0] LAST     = (INCLUDE_LINK != 0) ? IDX_W'(NUM_REGS)
                                                                : IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_index_q, out_index_d;
    logic              out_last_q, out_last_d;

    // State register and captured output word.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state logic: abort wins over start and handshake; capture happens in READ.
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;

        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_d   = '0;
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    out_data_d  = (idx_q == LINK_IDX) ? link_value : reg_value;
                    out_index_d = idx_q;
                    out_last_d  = (idx_q == LAST);
                    state_d     = S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (idx_q == LAST) begin
                            state_d = S_FIN;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_READ;
                        end
                    end
                end
                S_FIN: begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Bank address follows idx; parked at 0 when idle and held on the top register for the link slot.
    always_comb begin
        reg_addr = '0;
        if (state_q != S_IDLE) begin
            if (idx_q >= LINK_IDX) begin
                reg_addr = TOP_ADDR;
            end else begin
                reg_addr = idx_q[ADDR_W-1:0];
            end
        end
    end

    // Stream and status outputs decoded from state.
    always_comb begin
        out_valid = (state_q == S_SEND);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
        out_data  = out_data_q;
        out_index = out_index_q;
        out_last  = out_last_q;
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a register-array bank model drives both a
// link-emitting and a link-less instance; each dump is checked word by word
// against the expected list built from the bank contents.
module tb_reg_dump_reader;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;

    logic [DW-1:0] bank [0:NR-1];
    logic [DW-1:0] link_value;

    logic [AW-1:0] reg_addr, nl_reg_addr;
    logic [DW-1:0] reg_value, nl_reg_value;
    logic          out_valid, nl_out_valid;
    logic [DW-1:0] out_data, nl_out_data;
    logic [AW:0]   out_index, nl_out_index;
    logic          out_last, nl_out_last;
    logic          busy, nl_busy;
    logic          done, nl_done;

    assign reg_value    = bank[reg_addr];
    assign nl_reg_value = bank[nl_reg_addr];

    reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .INCLUDE_LINK(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .reg_addr(reg_addr), .reg_value(reg_value), .link_value(link_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .INCLUDE_LINK(0)) u_dut_nl (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .reg_addr(nl_reg_addr), .reg_value(nl_reg_value), .link_value(link_value),
        .out_valid(nl_out_valid), .out_ready(out_ready), .out_data(nl_out_data),
        .out_index(nl_out_index), .out_last(nl_out_last), .busy(nl_busy), .done(nl_done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Expected word per index; index NR is the link word.
    logic [DW-1:0] exp_data [0:NR];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample(input bit nl, output logic v, output logic [DW-1:0] d,
                          output logic [AW:0] ix, output logic l,
                          output logic dn, output logic b);
        if (nl) begin
            v = nl_out_valid; d = nl_out_data; ix = nl_out_index;
            l = nl_out_last;  dn = nl_done;    b = nl_busy;
        end else begin
            v = out_valid; d = out_data; ix = out_index;
            l = out_last;  dn = done;    b = busy;
        end
    endtask

    task automatic load_expected();
        for (int i = 0; i < NR; i++) exp_data[i] = bank[i];
        exp_data[NR] = link_value;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < NR; i++) bank[i] = 32'hA000_0000 + DW'(i);
        link_value = 32'hDEAD_BEEF;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NR; i++) bank[i] = $urandom;
        link_value = $urandom;
    endtask

    // Let whichever instance is still dumping run to completion.
    task automatic settle();
        out_ready = 1'b1;
        repeat (12) step();
    endtask

    // Run one dump on the selected instance and check every word.
    // stop_at: return while that index is presented (no handshake taken).
    // restart_at: pulse start while that index is presented.
    // write_at: write bank[5]=0x1234 while that index is presented.
    task automatic collect(input bit nl, input int pct, input int stop_at,
                           input int restart_at, input int write_at);
        int last;
        int next;
        int cycles;
        logic held;
        logic [DW-1:0] hd;
        logic [AW:0] hix;
        logic hl;
        logic v, l, dn, b, rdy;
        logic [DW-1:0] d;
        logic [AW:0] ix;

        last   = nl ? NR - 1 : NR;
        next   = 0;
        cycles = 0;
        held   = 1'b0;
        hd = '0; hix = '0; hl = 1'b0;

        start = 1'b1;
        step();
        start = 1'b0;
        sample(nl, v, d, ix, l, dn, b);
        total++;
        if (v !== 1'b0 || b !== 1'b1) begin
            bad++;
            $display("FAIL start_read: valid=%b busy=%b required valid=0 busy=1", v, b);
        end

        forever begin
            if (cycles > 3000) begin
                total++; bad++;
                $display("FAIL dump_timeout: got %0d words, required %0d", next, last + 1);
                return;
            end
            start = 1'b0;
            sample(nl, v, d, ix, l, dn, b);
            if (v === 1'b1) begin
                if (held) begin
                    total++;
                    if (d !== hd || ix !== hix || l !== hl) begin
                        bad++;
                        $display("FAIL stall_stable: data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                                 d, ix, l, hd, hix, hl);
                    end
                end
                if (stop_at >= 0 && int'(ix) == stop_at) return;
                if (!held && int'(ix) == restart_at) start = 1'b1;
                if (!held && int'(ix) == write_at) begin
                    bank[5] = 32'h0000_1234;
                    if (5 > int'(ix)) exp_data[5] = 32'h0000_1234;
                end
                rdy = ($urandom_range(0, 99) < pct);
                out_ready = rdy;
                if (rdy) begin
                    total++;
                    if (int'(ix) != next || d !== exp_data[next] || l !== (next == last)) begin
                        bad++;
                        $display("FAIL word: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                                 ix, d, l, next, exp_data[next], (next == last));
                    end
                    next++;
                    held = 1'b0;
                    if (next == last + 1) begin
                        step();
                        sample(nl, v, d, ix, l, dn, b);
                        total++;
                        if (dn !== 1'b1 || v !== 1'b0 || b !== 1'b1) begin
                            bad++;
                            $display("FAIL done_pulse: done=%b valid=%b busy=%b required 1 0 1", dn, v, b);
                        end
                        step();
                        sample(nl, v, d, ix, l, dn, b);
                        total++;
                        if (dn !== 1'b0 || b !== 1'b0) begin
                            bad++;
                            $display("FAIL back_idle: done=%b busy=%b required 0 0", dn, b);
                        end
                        return;
                    end
                end else begin
                    held = 1'b1; hd = d; hix = ix; hl = l;
                end
            end else begin
                total++;
                if (dn !== 1'b0) begin
                    bad++;
                    $display("FAIL early_done: done=%b required 0 at word %0d", dn, next);
                end
            end
            step();
            cycles++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0 ||
            out_index !== '0 || out_last !== 1'b0 || reg_addr !== '0) begin
            bad++;
            $display("FAIL %s: valid=%b busy=%b done=%b data=%h idx=%0d last=%b addr=%0d required all zero",
                     tag, out_valid, busy, done, out_data, out_index, out_last, reg_addr);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        check_reset_values("reset_state");
        total++;
        if (nl_busy !== 1'b0 || nl_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_nl: busy=%b valid=%b required 0 0", nl_busy, nl_out_valid);
        end
        #2 reset_n = 1'b1;
        step();
    endtask

    task automatic test_pattern_dump();
        fill_pattern();
        load_expected();
        collect(1'b0, 100, -1, -1, -1);
        settle();
    endtask

    task automatic test_backpressure();
        fill_random();
        load_expected();
        collect(1'b0, 30, -1, -1, -1);
        settle();
    endtask

    task automatic test_no_link();
        fill_pattern();
        load_expected();
        collect(1'b1, 100, -1, -1, -1);
        settle();
        fill_random();
        load_expected();
        collect(1'b1, 50, -1, -1, -1);
        settle();
    endtask

    task automatic test_abort();
        fill_random();
        load_expected();
        collect(1'b0, 100, 7, -1, -1);
        out_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: valid=%b busy=%b required 0 0", out_valid, busy);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_done: done=%b required 0", done);
            end
            step();
        end
        // start together with abort in IDLE must not launch a dump
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_idle: busy=%b required 0", busy);
        end
        collect(1'b0, 100, -1, -1, -1);
        settle();
    endtask

    task automatic test_restart_and_reset();
        fill_random();
        load_expected();
        collect(1'b0, 70, 20, 10, -1);
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        #2 reset_n = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL no_resume: busy=%b required 0", busy);
        end
        collect(1'b0, 100, -1, -1, -1);
        settle();
    endtask

    task automatic test_bank_write();
        fill_pattern();
        load_expected();
        collect(1'b0, 60, -1, -1, 3);
        total++;
        if (exp_data[5] !== 32'h0000_1234) begin
            bad++;
            $display("FAIL write_model: expected word5=%h required 00001234", exp_data[5]);
        end
        settle();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) bank[i] = '0;
        link_value = '0;
        test_reset();
        test_pattern_dump();
        test_backpressure();
        test_no_link();
        test_abort();
        test_restart_and_reset();
        test_bank_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
